apb_timer_slave: RTL and testbench

APB slave hosting a programmable down-counting timer with prescaler, auto-reload and a level interrupt. It sits directly downstream of the APB master, on the same PSEL/PENABLE/PADDR/PWRITE/PWDATA bus the GPIO slave uses, and returns PRDATA/PREADY/PSLVERR to the master. Its configurable access-phase wait states exercise the master's PREADY handling.

---
 rtl/apb_timer_slave.sv | 178 +++++++++++++++++
 tb/tb_apb_timer_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// APB slave with a programmable down-counting timer: prescaler, auto-reload, level irq.
// Latency: PREADY rises WAIT_STATES cycles after the first access cycle; irq is registered (+1 cycle).
// Backpressure: PREADY is held low for WAIT_STATES access cycles; dropping PSEL aborts with no commit.
//
// Ports:
//   PCLK, PRESETn                       clock, async active-low reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA APB request (only PADDR[7:0] decoded)
//   PRDATA, PREADY, PSLVERR             APB response
//   irq                                  level interrupt = EXPIRED && IRQ_EN
module apb_timer_slave #(
  parameter int WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  // ACCESS lasts WAIT_STATES cycles, so the counter starts one below it.
  localparam logic [2:0] W_START = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  state_t      r_state, w_phase, w_next;
  logic [2:0]  r_wait, w_wait_next;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        r_en, r_auto, r_irq_en, r_expired, r_irq;
  logic [31:0] r_load, r_value;
  logic [7:0]  r_prescale, r_pres_cnt;

  logic [7:0]  w_off;
  logic        w_mapped, w_err;
  logic [31:0] w_rmux;
  logic        w_commit, w_wr;
  logic        w_wr_ctrl, w_wr_load, w_wr_pres, w_wr_stat;
  logic        w_tick, w_expire;
  logic        w_unused;

  assign w_off    = PADDR[7:0];
  assign w_unused = ^PADDR[31:8];

  // Register decode and read mux.
  always_comb begin
    w_mapped = 1'b0;
    w_rmux   = '0;
    case (w_off)
      8'h00: begin w_mapped = 1'b1; w_rmux = {29'd0, r_irq_en, r_auto, r_en}; end
      8'h04: begin w_mapped = 1'b1; w_rmux = r_load;                          end
      8'h08: begin w_mapped = 1'b1; w_rmux = r_value;                         end
      8'h0C: begin w_mapped = 1'b1; w_rmux = {24'd0, r_prescale};             end
      8'h10: begin w_mapped = 1'b1; w_rmux = {31'd0, r_expired};              end
      default: ;
    endcase
  end

  assign w_err = !w_mapped || (PWRITE && (w_off == 8'h08));

  // The setup cycle is recognised combinationally so the ACCESS/DONE decision
  // lands on the edge that closes it; this is what makes a zero-wait transfer
  // show PREADY in the very first access cycle.
  always_comb begin
    w_phase     = r_state;
    w_next      = IDLE;
    w_wait_next = r_wait;
    if ((r_state == IDLE || r_state == DONE) && PSEL && !PENABLE)
      w_phase = SETUP;
    case (w_phase)
      SETUP: begin
        if (WAIT_STATES == 0) begin
          w_next = DONE;
        end else begin
          w_next      = ACCESS;
          w_wait_next = W_START;
        end
      end
      ACCESS: begin
        if (!(PSEL && PENABLE))
          w_next = IDLE;
        else if (r_wait == 3'd0)
          w_next = DONE;
        else begin
          w_next      = ACCESS;
          w_wait_next = r_wait - 3'd1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_wait  <= 3'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (w_phase == SETUP) begin
        r_rdata <= w_err ? 32'd0 : w_rmux;
        r_err   <= w_err;
      end
    end
  end

  assign PREADY  = (r_state == DONE);
  assign PSLVERR = PREADY && r_err;
  assign PRDATA  = (PREADY && !r_err) ? r_rdata : 32'd0;
  assign irq     = r_irq;

  assign w_commit  = (r_state == DONE) && PSEL && PENABLE;
  assign w_wr      = w_commit && PWRITE && !r_err;
  assign w_wr_ctrl = w_wr && (w_off == 8'h00);
  assign w_wr_load = w_wr && (w_off == 8'h04);
  assign w_wr_pres = w_wr && (w_off == 8'h0C);
  assign w_wr_stat = w_wr && (w_off == 8'h10);

  assign w_tick   = r_en && (r_pres_cnt == r_prescale);
  assign w_expire = w_tick && (r_value == 32'd0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_load     <= '0;
      r_value    <= '0;
      r_prescale <= '0;
      r_pres_cnt <= '0;
      r_expired  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= r_expired && r_irq_en;

      if (!r_en || w_wr_pres || w_tick)
        r_pres_cnt <= 8'd0;
      else
        r_pres_cnt <= r_pres_cnt + 8'd1;

      // A bus write to LOAD wins over the tick decrement/reload.
      if (w_wr_load)
        r_value <= PWDATA;
      else if (w_tick) begin
        if (r_value != 32'd0)
          r_value <= r_value - 32'd1;
        else if (r_auto)
          r_value <= r_load;
      end

      // Expiry set wins over a software clear in the same cycle.
      if (w_expire)
        r_expired <= 1'b1;
      else if (w_wr_stat && PWDATA[0])
        r_expired <= 1'b0;

      // A CTRL write wins over the one-shot auto-disable.
      if (w_wr_ctrl) begin
        r_en     <= PWDATA[0];
        r_auto   <= PWDATA[1];
        r_irq_en <= PWDATA[2];
      end else if (w_expire && !r_auto)
        r_en <= 1'b0;

      if (w_wr_load) r_load     <= PWDATA;
      if (w_wr_pres) r_prescale <= PWDATA[7:0];
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
module tb_apb_timer_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn, PENABLE, PWRITE;
  logic [2:0]  psel;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic        irq_o   [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_timer_slave #(.WAIT_STATES(1)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .irq(irq_o[0]));

  apb_timer_slave #(.WAIT_STATES(0)) u_dut_ws0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .irq(irq_o[1]));

  apb_timer_slave #(.WAIT_STATES(3)) u_dut_ws3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .irq(irq_o[2]));

  // Reference model of the main (WAIT_STATES=1) instance's timer.
  bit          m_en, m_ar, m_ie, m_exp, m_irq;
  logic [31:0] m_load, m_val;
  logic [7:0]  m_ps, m_pc;
  bit          m_wv;
  logic [7:0]  m_wa;
  logic [31:0] m_wd;

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_irq = 0;
    m_load = 0; m_val = 0; m_ps = 0; m_pc = 0; m_wv = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[7:0])
      8'h00:   return {29'd0, m_ie, m_ar, m_en};
      8'h04:   return m_load;
      8'h08:   return m_val;
      8'h0C:   return {24'd0, m_ps};
      8'h10:   return {31'd0, m_exp};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_err(input logic [31:0] a, input bit wr);
    logic [7:0] o;
    o = a[7:0];
    if (!(o == 8'h00 || o == 8'h04 || o == 8'h08 || o == 8'h0C || o == 8'h10)) return 1'b1;
    return wr && (o == 8'h08);
  endfunction

  // One clock of the timer rules, with any bus write committing this cycle applied.
  task automatic model_step();
    bit         tick, expire, n_en, n_exp;
    logic [31:0] n_val;
    logic [7:0]  n_pc;
    if (!PRESETn) begin model_reset(); return; end
    tick   = m_en && (m_pc == m_ps);
    expire = tick && (m_val == 0);
    n_pc   = (!m_en || tick || (m_wv && m_wa == 8'h0C)) ? 8'd0 : m_pc + 8'd1;
    n_val  = m_val;
    if (tick) n_val = (m_val != 0) ? m_val - 1 : (m_ar ? m_load : 32'd0);
    if (m_wv && m_wa == 8'h04) n_val = m_wd;
    n_exp = m_exp;
    if (m_wv && m_wa == 8'h10 && m_wd[0]) n_exp = 0;
    if (expire) n_exp = 1;
    n_en = m_en;
    if (expire && !m_ar) n_en = 0;
    m_irq = m_exp && m_ie;
    if (m_wv && m_wa == 8'h00) begin n_en = m_wd[0]; m_ar = m_wd[1]; m_ie = m_wd[2]; end
    if (m_wv && m_wa == 8'h04) m_load = m_wd;
    if (m_wv && m_wa == 8'h0C) m_ps = m_wd[7:0];
    m_en = n_en; m_exp = n_exp; m_val = n_val; m_pc = n_pc;
    m_wv = 0;
  endtask

  task automatic cyc();
    @(posedge PCLK);
    model_step();
    @(negedge PCLK);
    check_b("irq", irq_o[0], m_irq);
  endtask

  task automatic apb(input int sel, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_er);
    int ws;
    ws = ws_of(sel);
    psel = 3'b000; psel[sel] = 1'b1;
    PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d;
    cyc();
    PENABLE = 1;
    for (int k = 0; k < ws; k++) begin
      check_b("wait_pready", pready[sel], 1'b0);
      check_b("wait_pslverr", pslverr[sel], 1'b0);
      check("wait_prdata", prdata[sel], 32'd0);
      cyc();
    end
    check_b("pready", pready[sel], 1'b1);
    check_b("pslverr", pslverr[sel], exp_er);
    if (!wr) check("prdata", prdata[sel], exp_rd);
    if (sel == 0 && wr && !exp_er) begin m_wv = 1; m_wa = a[7:0]; m_wd = d; end
    cyc();
    psel = 3'b000; PENABLE = 0;
  endtask

  task automatic mrd(input logic [31:0] a);
    apb(0, 1'b0, a, 32'd0, m_read(a), m_err(a, 1'b0));
  endtask

  task automatic mwr(input logic [31:0] a, input logic [31:0] d);
    apb(0, 1'b1, a, d, 32'd0, m_err(a, 1'b1));
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 3; s++) begin
      check({tag, "_prdata"}, prdata[s], 32'd0);
      check_b({tag, "_pready"}, pready[s], 1'b0);
      check_b({tag, "_pslverr"}, pslverr[s], 1'b0);
      check_b({tag, "_irq"}, irq_o[s], 1'b0);
    end
  endtask

  logic [31:0] addr_tab [8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h02, 32'h104};

  initial begin
    PRESETn = 0; psel = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    model_reset();
    @(negedge PCLK);
    check_all_zero("por");
    cyc();
    PRESETn = 1;
    cyc();

    // Reset readback on every instance.
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < 5; r++)
        apb(s, 1'b0, 32'(r * 4), 32'd0, 32'd0, 1'b0);

    // One-shot: 3,2,1,0 then expiry.
    mwr(32'h04, 32'd3);
    mwr(32'h0C, 32'd0);
    mwr(32'h00, 32'h5);
    apb(0, 1'b0, 32'h08, 32'd0, 32'd3, 1'b0);
    apb(0, 1'b0, 32'h08, 32'd0, 32'd0, 1'b0);
    apb(0, 1'b0, 32'h10, 32'd0, 32'd1, 1'b0);
    apb(0, 1'b0, 32'h00, 32'd0, 32'h4, 1'b0);
    check_b("oneshot_irq", irq_o[0], 1'b1);
    repeat (3) cyc();
    mrd(32'h08);

    // Reset in the middle of a LOAD write: outputs drop immediately, nothing commits.
    psel = 3'b001; PENABLE = 0; PWRITE = 1; PADDR = 32'h04; PWDATA = 32'h55;
    cyc();
    PENABLE = 1;
    cyc();
    check_b("pre_reset_pready", pready[0], 1'b1);
    #2 PRESETn = 0;
    #1 check_all_zero("async_reset");
    model_reset();
    cyc();
    PRESETn = 1; psel = 0; PENABLE = 0;
    cyc();
    apb(0, 1'b0, 32'h04, 32'd0, 32'd0, 1'b0);

    // Auto-reload with prescaler.
    mwr(32'h04, 32'd2);
    mwr(32'h0C, 32'd3);
    mwr(32'h00, 32'h7);
    for (int i = 0; i < 10; i++) begin
      mrd(32'h08);
      if (i % 3 == 2) begin mrd(32'h10); mwr(32'h10, 32'd1); end
    end

    // Clear vs set race: expiry every cycle, so the clear loses.
    mwr(32'h00, 32'h0);
    mwr(32'h04, 32'd0);
    mwr(32'h0C, 32'd0);
    mwr(32'h00, 32'h7);
    mwr(32'h10, 32'd1);
    apb(0, 1'b0, 32'h10, 32'd0, 32'd1, 1'b0);
    mwr(32'h00, 32'h4);
    repeat (2) cyc();
    mwr(32'h10, 32'd1);
    check_b("clr_irq_still", irq_o[0], 1'b1);
    cyc();
    check_b("clr_irq_drop", irq_o[0], 1'b0);
    apb(0, 1'b0, 32'h10, 32'd0, 32'd0, 1'b0);

    // Error responses.
    mwr(32'h04, 32'd9);
    apb(0, 1'b1, 32'h08, 32'h1234, 32'd0, 1'b1);
    apb(0, 1'b0, 32'h08, 32'd0, 32'd9, 1'b0);
    apb(0, 1'b0, 32'h14, 32'd0, 32'd0, 1'b1);
    apb(0, 1'b0, 32'h02, 32'd0, 32'd0, 1'b1);
    apb(0, 1'b1, 32'h06, 32'hFF, 32'd0, 1'b1);
    for (int r = 0; r < 5; r++) mrd(32'(r * 4));

    // Zero-wait instance: back-to-back 2-cycle transfers.
    apb(1, 1'b1, 32'h04, 32'hDEADBEEF, 32'd0, 1'b0);
    apb(1, 1'b0, 32'h04, 32'd0, 32'hDEADBEEF, 1'b0);
    apb(1, 1'b1, 32'h0C, 32'h1AB, 32'd0, 1'b0);
    apb(1, 1'b0, 32'h0C, 32'd0, 32'hAB, 1'b0);
    apb(1, 1'b0, 32'h14, 32'd0, 32'd0, 1'b1);

    // Three-wait instance, plus an aborted write that must not commit.
    apb(2, 1'b1, 32'h04, 32'hA5, 32'd0, 1'b0);
    apb(2, 1'b0, 32'h04, 32'd0, 32'hA5, 1'b0);
    psel = 3'b100; PENABLE = 0; PWRITE = 1; PADDR = 32'h04; PWDATA = 32'h77;
    cyc();
    PENABLE = 1;
    repeat (2) begin check_b("abort_wait", pready[2], 1'b0); cyc(); end
    psel = 3'b000;
    cyc();
    check_b("abort_pready", pready[2], 1'b0);
    PENABLE = 0;
    cyc();
    apb(2, 1'b0, 32'h04, 32'd0, 32'hA5, 1'b0);

    // Randomized traffic on the main instance against the model.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 7))
        0: mwr(32'h00, $urandom());
        1: mwr(32'h04, $urandom_range(0, 12));
        2: mwr(32'h0C, ($urandom() & 32'hFFFFFF00) | $urandom_range(0, 3));
        3: mwr(32'h10, $urandom());
        4: mwr(addr_tab[$urandom_range(0, 7)], $urandom_range(0, 20));
        5, 6: mrd(addr_tab[$urandom_range(0, 7)]);
        default: repeat ($urandom_range(1, 4)) cyc();
      endcase
    end
    for (int r = 0; r < 5; r++) mrd(32'(r * 4));

    check_b("ws0_irq", irq_o[1], 1'b0);
    check_b("ws3_irq", irq_o[2], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
